// File: rtl/mmss_timer_pkg.sv
// Shared types and constants for the mm:ss countdown/stopwatch timer.
package mmss_timer_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SEC_PER_MIN = 60;

  // Nibble positions inside the 16-bit bcd word.
  localparam int NIB_MIN_TENS = 3;
  localparam int NIB_MIN_ONES = 2;
  localparam int NIB_SEC_TENS = 1;
  localparam int NIB_SEC_ONES = 0;

endpackage

// File: rtl/mmss_to_bcd.sv
// Splits a seconds count into mm:ss and packs it as four BCD nibbles.
// Purely combinational; no flow control.
module mmss_to_bcd
  import mmss_timer_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] secs,
  output logic [15:0]  bcd
);

  logic [W-1:0] mins;
  logic [W-1:0] sec_f;

  always_comb begin
    mins  = secs / W'(SEC_PER_MIN);
    sec_f = secs - mins * W'(SEC_PER_MIN);
    bcd   = '0;
    bcd[NIB_MIN_TENS*4 +: 4] = 4'(mins / W'(10));
    bcd[NIB_MIN_ONES*4 +: 4] = 4'(mins % W'(10));
    bcd[NIB_SEC_TENS*4 +: 4] = 4'(sec_f / W'(10));
    bcd[NIB_SEC_ONES*4 +: 4] = 4'(sec_f % W'(10));
  end

endmodule

// File: rtl/mmss_timer.sv
// mm:ss countdown timer / stopwatch with pause, repeat-run and lap hold.
// Outputs registered one clock after state/value change; inputs are single-cycle pulses, no backpressure.
module mmss_timer
  import mmss_timer_pkg::*;
#(
  parameter int MIN_MAX  = 59,
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_en,
  input  logic        dir,
  input  logic        start_pulse,
  input  logic        clear_pulse,
  input  logic        min_pulse,
  input  logic        sec_pulse,
  input  logic        hold_pulse,
  output logic [15:0] bcd,
  output logic        running,
  output logic        done,
  output logic        alarm,
  output logic        held
);

  localparam int W  = $clog2((MIN_MAX + 1) * SEC_PER_MIN);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [W-1:0]  LIMIT     = W'(MIN_MAX * SEC_PER_MIN + 59);
  localparam logic [W-1:0]  LIMIT_M1  = W'(MIN_MAX * SEC_PER_MIN + 58);
  localparam logic [W-1:0]  MIN_SPAN  = W'(MIN_MAX * SEC_PER_MIN);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  value_q, value_d;
  logic [W-1:0]  preset_q, preset_d;
  logic [W-1:0]  snap_q, snap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          held_q, held_d;
  logic          running_q, alarm_q;
  logic [15:0]   bcd_q, bcd_nxt;

  logic [W-1:0]  mins, secs, set_val, disp_val;
  logic          sec_evt;

  // Minute and second fields wrap independently while setting.
  always_comb begin
    mins    = value_q / W'(SEC_PER_MIN);
    secs    = value_q - mins * W'(SEC_PER_MIN);
    set_val = value_q;
    if (min_pulse)
      set_val = (mins == W'(MIN_MAX)) ? set_val - MIN_SPAN : set_val + W'(SEC_PER_MIN);
    if (sec_pulse)
      set_val = (secs == W'(59)) ? set_val - W'(59) : set_val + W'(1);
  end

  assign sec_evt = tick_en && (presc_q == PRESC_TOP);

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    preset_d = preset_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    held_d   = held_q;
    snap_d   = snap_q;

    if (clear_pulse) begin
      state_d = ST_SET;
      value_d = '0;
      presc_d = '0;
      held_d  = 1'b0;
    end else begin
      case (state_q)
        ST_SET: begin
          if (start_pulse) begin
            // A countdown from zero has nothing to count; stay in SET.
            if (dir || (value_q != '0)) begin
              dir_d    = dir;
              preset_d = value_q;
              state_d  = ST_RUN;
            end
          end else if (min_pulse || sec_pulse) begin
            value_d = set_val;
          end
        end
        ST_RUN: begin
          if (start_pulse) begin
            state_d = ST_PAUSE;
          end else if (tick_en) begin
            presc_d = sec_evt ? '0 : presc_q + PW'(1);
            if (sec_evt) begin
              if (!dir_q) begin
                value_d = value_q - W'(1);
                if (value_q == W'(1)) state_d = ST_DONE;
              end else if (value_q >= LIMIT_M1) begin
                value_d = LIMIT;
                state_d = ST_DONE;
              end else begin
                value_d = value_q + W'(1);
              end
            end
          end
        end
        ST_PAUSE: begin
          if (start_pulse) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (start_pulse) begin
            value_d = preset_q;
            presc_d = '0;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_SET;
      endcase

      if (hold_pulse && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
        held_d = !held_q;
        if (!held_q) snap_d = value_q;
      end
    end

    if ((state_d == ST_SET) || (state_d == ST_DONE)) held_d = 1'b0;
  end

  assign disp_val = held_q ? snap_q : value_q;

  mmss_to_bcd #(.W(W)) u_to_bcd (
    .secs (disp_val),
    .bcd  (bcd_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SET;
      value_q   <= '0;
      preset_q  <= '0;
      snap_q    <= '0;
      presc_q   <= '0;
      dir_q     <= 1'b0;
      held_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      bcd_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      preset_q  <= preset_d;
      snap_q    <= snap_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      held_q    <= held_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_DONE) && (state_q != ST_DONE);
      bcd_q     <= bcd_nxt;
    end
  end

  assign bcd     = bcd_q;
  assign running = running_q;
  assign done    = (state_q == ST_DONE);
  assign alarm   = alarm_q;
  assign held    = held_q;

endmodule

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 The block SHALL have parameter MIN_MAX, default 59; meaning: the highest settable minute value, legal range 1..99.
REQ-002 The block SHALL have parameter TICK_DIV, default 1; meaning: the number of tick_en pulses per counted second, legal range 1..1023.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick_en  in  1  single-cycle time-base strobe.
- dir  in  1  count direction: 0 = countdown, 1 = count-up (stopwatch).
- start_pulse  in  1  one-cycle start/pause toggle.
- clear_pulse  in  1  one-cycle clear.
- min_pulse  in  1  one-cycle minute increment.
- sec_pulse  in  1  one-cycle second increment.
- hold_pulse  in  1  one-cycle display-freeze (lap) toggle.
- bcd  out  16  {min tens, min ones, sec tens, sec ones}.
- running  out  1  high in state RUN.
- done  out  1  level, high in state DONE.
- alarm  out  1  one-cycle pulse on entry to DONE.
- held  out  1  display frozen.

Function
REQ-004 The block SHALL keep one time register, value, in seconds, W = clog2((MIN_MAX+1)*60) bits wide; LIMIT = MIN_MAX*60+59.
REQ-005 The block SHALL implement an FSM with states SET, RUN, PAUSE, DONE.
REQ-006 Input priority within a cycle SHALL be: clear_pulse > start_pulse > tick_en > min_pulse/sec_pulse.
REQ-007 clear_pulse in any state SHALL set value=0, set the prescaler to 0, clear held and go to SET on the next clock.
REQ-008 In SET, min_pulse SHALL add 60, wrapping from minute MIN_MAX to minute 0 with seconds unchanged.
REQ-009 In SET, sec_pulse SHALL increment the seconds field, wrapping 59->0 with no carry into minutes.
REQ-010 In SET, simultaneous min_pulse and sec_pulse SHALL both apply in the same cycle.
REQ-011 In SET, start_pulse SHALL latch dir into dir_q and value into preset, then enter RUN.
REQ-012 Exception to REQ-011: if dir=0 and value=0, start_pulse SHALL be ignored and the FSM stays in SET.
REQ-013 dir SHALL be ignored outside SET.
REQ-014 In RUN, tick_en SHALL advance a prescaler 0..TICK_DIV-1; the wrap of the prescaler is the "second event".
REQ-015 On a second event with dir_q=0, value SHALL decrement; a decrement reaching 0 SHALL enter DONE in the same cycle the register updates.
REQ-016 On a second event with dir_q=1, value SHALL increment; an increment reaching LIMIT SHALL enter DONE (saturate, no wrap).
REQ-017 In RUN, start_pulse SHALL enter PAUSE, with value and the prescaler frozen.
REQ-018 In PAUSE, start_pulse SHALL return to RUN, and the prescaler SHALL resume from its frozen count.
REQ-019 In RUN, PAUSE and DONE, min_pulse and sec_pulse SHALL be ignored.
REQ-020 alarm SHALL be high exactly one cycle: the first cycle the FSM is in DONE.
REQ-021 In DONE, start_pulse SHALL reload value from preset, zero the prescaler and enter RUN (repeat run).
REQ-022 hold_pulse in RUN or PAUSE SHALL toggle held.
REQ-023 While held=1, bcd SHALL show a snapshot of value taken at the set edge while counting continues.
REQ-024 Entering DONE or SET SHALL clear held.
REQ-025 bcd SHALL be registered and reflect the displayed value one clock after value changes.
REQ-026 Each bcd nibble SHALL be 0..9.
REQ-027 running SHALL equal (state==RUN) as a registered output.

Reset
REQ-028 reset low SHALL asynchronously force: state=SET, value=0, preset=0, prescaler=0, dir_q=0, held=0, snapshot=0.
REQ-029 reset low SHALL asynchronously force: bcd=16'h0000, running=0, done=0, alarm=0.
REQ-030 Reset asserted mid-RUN SHALL abandon the count with no alarm.
REQ-031 After reset release, the first clock edge SHALL be a normal SET cycle.

Structure
REQ-032 A shared package SHALL hold the state enum (SET, RUN, PAUSE, DONE), SEC_PER_MIN=60 and the bcd nibble-order constants.
REQ-033 The seconds-to-BCD conversion (min/sec split, tens/ones) SHALL be a sub-module, mmss_to_bcd, parameterised by W.
REQ-034 The FSM, counter, prescaler and snapshot logic SHALL remain in mmss_timer.

Verification
REQ-035 Set and count down: MIN_MAX=59, TICK_DIV=1; 2x min_pulse, 5x sec_pulse, dir=0, start_pulse -> bcd=0205 after setting; after 125 ticks done=1, a single alarm pulse, bcd=0000.
REQ-036 Wrap and rejection: from 59:59 in SET, one min_pulse -> 00:59; then one sec_pulse -> 00:00; then dir=0 with start_pulse -> state stays SET, running=0.
REQ-037 Stopwatch saturation: MIN_MAX=1, dir=1, start from 00:00, 119 ticks -> bcd=0159, done=1; further ticks change nothing.
REQ-038 Pause and prescaler: TICK_DIV=4; RUN, 6 ticks, start_pulse, 10 ticks, start_pulse, 2 ticks -> value advanced by exactly 2 seconds.
REQ-039 Hold: RUN 03:00 down, hold_pulse, 30 ticks -> bcd stays 0300 while value=150; second hold_pulse -> bcd=0230 one cycle later.
REQ-040 Priority and reset: clear_pulse together with start_pulse and tick_en in RUN -> SET with value 0; reset pulse low mid-RUN -> all outputs 0 immediately, no alarm.
